// File: rtl/pipe_dest_tracker_pkg.sv
// pipe_dest_tracker_pkg: shared widths, zero register and the per-stage destination tag
package pipe_dest_tracker_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic regWrite;
        logic memRead;
    } stageTag_t;
    localparam stageTag_t BUBBLE = '0;
endpackage

// File: rtl/pipe_dest_tracker_if.sv
// pipe_dest_tracker_if: decode/EX/MEM inputs and stage-tag/writeback outputs of the tracker
//   master: decode/datapath side driving stall_in, flush, id_*, if_id*, ex_alu_result, mem_rdata
//   slave : the tracker, driving ID/EX, EX/MEM, MEM/WB tags, writeback port, load_use_stall, stall_count
interface pipe_dest_tracker_if
    import pipe_dest_tracker_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW
);
    logic stall_in;
    logic flush;
    logic [AW-1:0] id_Rd;
    logic id_RegWrite;
    logic id_MemRead;
    logic [AW-1:0] if_idRs;
    logic [AW-1:0] if_idRt;
    logic [DW-1:0] ex_alu_result;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] id_exRd;
    logic id_exRegWrite;
    logic id_exMemRead;
    logic [AW-1:0] ex_memRd;
    logic ex_memRegWrite;
    logic ex_memMemRead;
    logic [DW-1:0] ex_memAlu;
    logic [AW-1:0] mem_wbRd;
    logic mem_wbRegWrite;
    logic [DW-1:0] mem_wbData;
    logic wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdata;
    logic load_use_stall;
    logic [15:0] stall_count;
    modport master (
        output stall_in, flush, id_Rd, id_RegWrite, id_MemRead, if_idRs, if_idRt, ex_alu_result, mem_rdata,
        input id_exRd, id_exRegWrite, id_exMemRead, ex_memRd, ex_memRegWrite, ex_memMemRead, ex_memAlu,
              mem_wbRd, mem_wbRegWrite, mem_wbData, wb_we, wb_addr, wb_wdata, load_use_stall, stall_count
    );
    modport slave (
        input stall_in, flush, id_Rd, id_RegWrite, id_MemRead, if_idRs, if_idRt, ex_alu_result, mem_rdata,
        output id_exRd, id_exRegWrite, id_exMemRead, ex_memRd, ex_memRegWrite, ex_memMemRead, ex_memAlu,
               mem_wbRd, mem_wbRegWrite, mem_wbData, wb_we, wb_addr, wb_wdata, load_use_stall, stall_count
    );
endinterface

// File: rtl/pipe_dest_tracker_load_use_detector.sv
// load_use_detector: flags a load in ID/EX whose nonzero destination is read by the instruction in decode
//   idEx         in  ID/EX stage tag
//   rs, rt       in  decode-stage source registers
//   loadUseStall out one-cycle freeze request
module load_use_detector
    import pipe_dest_tracker_pkg::*;
(
    input  stageTag_t         idEx,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    output logic              loadUseStall
);
    assign loadUseStall = idEx.memRead && idEx.regWrite && idEx.rd != REG_ZERO && (idEx.rd == rs || idEx.rd == rt);
endmodule

// File: rtl/pipe_dest_tracker.sv
// pipe_dest_tracker: carries destination tags and results through ID/EX, EX/MEM, MEM/WB, inserts load-use bubbles
//   clk   in  core clock, rising edge
//   rst_n in  asynchronous active-low reset
//   bus   slave side of pipe_dest_tracker_if (stage tags, forwarding data, writeback port, stall outputs)
module pipe_dest_tracker
    import pipe_dest_tracker_pkg::*;
#(
    parameter int DATA_W = pipe_dest_tracker_pkg::DATA_W,
    parameter int REG_AW = pipe_dest_tracker_pkg::REG_AW
)(
    input logic clk,
    input logic rst_n,
    pipe_dest_tracker_if.slave bus
);
    stageTag_t idEx, exMem;
    logic [REG_AW-1:0] memWbRd;
    logic memWbRegWrite;
    logic [DATA_W-1:0] exMemAlu, memWbData;
    logic [15:0] stallCount;
    logic loadUseStall;

    load_use_detector uDetect (
        .idEx        (idEx),
        .rs          (bus.if_idRs),
        .rt          (bus.if_idRt),
        .loadUseStall(loadUseStall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idEx          <= BUBBLE;
            exMem         <= BUBBLE;
            exMemAlu      <= '0;
            memWbRd       <= REG_ZERO;
            memWbRegWrite <= 1'b0;
            memWbData     <= '0;
            stallCount    <= '0;
        end else if (!bus.stall_in) begin
            // A flush coinciding with a load-use still yields just one bubble.
            idEx          <= (loadUseStall || bus.flush) ? BUBBLE : '{rd: bus.id_Rd, regWrite: bus.id_RegWrite, memRead: bus.id_MemRead};
            exMem         <= idEx;
            exMemAlu      <= bus.ex_alu_result;
            memWbRd       <= exMem.rd;
            memWbRegWrite <= exMem.regWrite;
            memWbData     <= exMem.memRead ? bus.mem_rdata : exMemAlu;
            if (loadUseStall && stallCount != 16'hFFFF)
                stallCount <= stallCount + 16'd1;
        end
    end

    assign bus.id_exRd        = idEx.rd;
    assign bus.id_exRegWrite  = idEx.regWrite;
    assign bus.id_exMemRead   = idEx.memRead;
    assign bus.ex_memRd       = exMem.rd;
    assign bus.ex_memRegWrite = exMem.regWrite;
    assign bus.ex_memMemRead  = exMem.memRead;
    assign bus.ex_memAlu      = exMemAlu;
    assign bus.mem_wbRd       = memWbRd;
    assign bus.mem_wbRegWrite = memWbRegWrite;
    assign bus.mem_wbData     = memWbData;
    assign bus.wb_we          = memWbRegWrite && memWbRd != REG_ZERO;
    assign bus.wb_addr        = memWbRd;
    assign bus.wb_wdata       = memWbData;
    assign bus.load_use_stall = loadUseStall;
    assign bus.stall_count    = stallCount;
endmodule

// File: tb/tb_pipe_dest_tracker.sv
// tb_pipe_dest_tracker: directed scenario tasks for pipe_dest_tracker with hand-computed expectations
module tb_pipe_dest_tracker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    pipe_dest_tracker_if bus();

    pipe_dest_tracker dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic [4:0] rd, input logic rw, input logic mr, input logic [4:0] rs, input logic [4:0] rt);
        bus.id_Rd = rd;
        bus.id_RegWrite = rw;
        bus.id_MemRead = mr;
        bus.if_idRs = rs;
        bus.if_idRt = rt;
    endtask

    task automatic drain();
        setId(0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        setId(7, 1, 1, 0, 0);
        bus.ex_alu_result = 32'h1234;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.id_exRd !== 5'd0 || bus.id_exRegWrite !== 1'b0 || bus.id_exMemRead !== 1'b0) begin errors++; $display("FAIL reset_idex got %0d/%b/%b want 0/0/0", bus.id_exRd, bus.id_exRegWrite, bus.id_exMemRead); end
        checks++; if (bus.ex_memRd !== 5'd0 || bus.ex_memAlu !== 32'd0 || bus.ex_memMemRead !== 1'b0) begin errors++; $display("FAIL reset_exmem got %0d/%h/%b want 0/0/0", bus.ex_memRd, bus.ex_memAlu, bus.ex_memMemRead); end
        checks++; if (bus.mem_wbRd !== 5'd0 || bus.mem_wbData !== 32'd0 || bus.wb_we !== 1'b0 || bus.wb_wdata !== 32'd0) begin errors++; $display("FAIL reset_memwb got %0d/%h/%b want 0/0/0", bus.mem_wbRd, bus.mem_wbData, bus.wb_we); end
        checks++; if (bus.stall_count !== 16'd0 || bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0d/%b want 0/0", bus.stall_count, bus.load_use_stall); end
        tick();
        rst_n = 1'b1;
        setId(5, 1, 0, 0, 0);
        tick();
        setId(0, 0, 0, 0, 0);
        bus.ex_alu_result = 32'h55;
        tick();
        bus.ex_alu_result = 32'h0;
        checks++; if (bus.mem_wbRd !== 5'd0 || bus.ex_memRd !== 5'd5) begin errors++; $display("FAIL latency_early got memwb=%0d exmem=%0d want 0/5", bus.mem_wbRd, bus.ex_memRd); end
        tick();
        checks++; if (bus.mem_wbRd !== 5'd5 || bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd5 || bus.wb_wdata !== 32'h55) begin errors++; $display("FAIL first_wb got rd=%0d we=%b addr=%0d data=%h want 5/1/5/55", bus.mem_wbRd, bus.wb_we, bus.wb_addr, bus.wb_wdata); end
    endtask

    task automatic test_load_use();
        drain();
        setId(3, 1, 1, 0, 0);
        bus.ex_alu_result = 32'h0;
        tick();
        setId(4, 1, 0, 3, 1);
        bus.ex_alu_result = 32'h1000;
        #1;
        checks++; if (bus.load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_detect got %b want 1", bus.load_use_stall); end
        tick();
        bus.ex_alu_result = 32'h0;
        bus.mem_rdata = 32'hDEADBEEF;
        checks++; if (bus.id_exRd !== 5'd0 || bus.id_exRegWrite !== 1'b0 || bus.ex_memMemRead !== 1'b1 || bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_bubble got rd=%0d rw=%b exmr=%b cnt=%0d want 0/0/1/1", bus.id_exRd, bus.id_exRegWrite, bus.ex_memMemRead, bus.stall_count); end
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got %b want 0", bus.load_use_stall); end
        tick();
        bus.mem_rdata = 32'h0;
        checks++; if (bus.wb_we !== 1'b1 || bus.wb_addr !== 5'd3 || bus.wb_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lu_wb got we=%b addr=%0d data=%h want 1/3/deadbeef", bus.wb_we, bus.wb_addr, bus.wb_wdata); end
        checks++; if (bus.id_exRd !== 5'd4 || bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_resume got rd=%0d cnt=%0d want 4/1", bus.id_exRd, bus.stall_count); end
    endtask

    task automatic test_load_r0();
        drain();
        setId(0, 1, 1, 0, 0);
        tick();
        setId(4, 1, 0, 0, 0);
        #1;
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL r0_nostall got %b want 0", bus.load_use_stall); end
        tick();
        setId(0, 0, 0, 0, 0);
        checks++; if (bus.id_exRd !== 5'd4) begin errors++; $display("FAIL r0_advance got %0d want 4", bus.id_exRd); end
        tick();
        checks++; if (bus.mem_wbRegWrite !== 1'b1 || bus.wb_we !== 1'b0 || bus.stall_count !== 16'd1) begin errors++; $display("FAIL r0_wb got rw=%b we=%b cnt=%0d want 1/0/1", bus.mem_wbRegWrite, bus.wb_we, bus.stall_count); end
    endtask

    task automatic test_forward_distance();
        drain();
        setId(3, 1, 1, 0, 0);
        tick();
        setId(8, 1, 0, 0, 0);
        tick();
        setId(4, 1, 0, 3, 0);
        #1;
        checks++; if (bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL dist2_nostall got %b want 0", bus.load_use_stall); end
    endtask

    task automatic test_freeze();
        drain();
        setId(9, 1, 0, 0, 0);
        tick();
        setId(3, 1, 1, 0, 0);
        tick();
        setId(4, 1, 0, 3, 3);
        bus.stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.load_use_stall !== 1'b1) begin errors++; $display("FAIL frz_lus cycle %0d got %b want 1", i, bus.load_use_stall); end
            tick();
        end
        checks++; if (bus.id_exRd !== 5'd3 || bus.id_exMemRead !== 1'b1 || bus.ex_memRd !== 5'd9 || bus.mem_wbRd !== 5'd0 || bus.stall_count !== 16'd1) begin errors++; $display("FAIL frz_hold got idex=%0d mr=%b exmem=%0d memwb=%0d cnt=%0d want 3/1/9/0/1", bus.id_exRd, bus.id_exMemRead, bus.ex_memRd, bus.mem_wbRd, bus.stall_count); end
        bus.stall_in = 1'b0;
        tick();
        checks++; if (bus.id_exRegWrite !== 1'b0 || bus.id_exRd !== 5'd0 || bus.mem_wbRd !== 5'd9 || bus.stall_count !== 16'd2 || bus.load_use_stall !== 1'b0) begin errors++; $display("FAIL frz_bubble got rw=%b rd=%0d memwb=%0d cnt=%0d lus=%b want 0/0/9/2/0", bus.id_exRegWrite, bus.id_exRd, bus.mem_wbRd, bus.stall_count, bus.load_use_stall); end
        tick();
        checks++; if (bus.id_exRd !== 5'd4 || bus.stall_count !== 16'd2) begin errors++; $display("FAIL frz_single got rd=%0d cnt=%0d want 4/2", bus.id_exRd, bus.stall_count); end
    endtask

    task automatic test_flush();
        drain();
        setId(3, 1, 1, 0, 0);
        tick();
        setId(4, 1, 0, 0, 3);
        bus.flush = 1'b1;
        tick();
        checks++; if (bus.id_exRegWrite !== 1'b0 || bus.id_exRd !== 5'd0 || bus.stall_count !== 16'd3) begin errors++; $display("FAIL flush_lu got rw=%b rd=%0d cnt=%0d want 0/0/3", bus.id_exRegWrite, bus.id_exRd, bus.stall_count); end
        setId(6, 1, 0, 0, 0);
        tick();
        checks++; if (bus.id_exRegWrite !== 1'b0 || bus.id_exRd !== 5'd0 || bus.stall_count !== 16'd3) begin errors++; $display("FAIL flush_only got rw=%b rd=%0d cnt=%0d want 0/0/3", bus.id_exRegWrite, bus.id_exRd, bus.stall_count); end
        bus.flush = 1'b0;
        tick();
        checks++; if (bus.id_exRd !== 5'd6 || bus.id_exRegWrite !== 1'b1) begin errors++; $display("FAIL flush_release got rd=%0d rw=%b want 6/1", bus.id_exRd, bus.id_exRegWrite); end
    endtask

    task automatic test_saturation();
        bus.stall_in = 1'b1;
        force dut.stallCount = 16'hFFFE;
        #1;
        release dut.stallCount;
        tick();
        bus.stall_in = 1'b0;
        checks++; if (bus.stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got %h want fffe", bus.stall_count); end
        for (int i = 0; i < 3; i++) begin
            setId(3, 1, 1, 0, 0);
            tick();
            setId(4, 1, 0, 3, 0);
            tick();
            checks++; if (bus.stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_event %0d got %h want ffff", i, bus.stall_count); end
        end
    endtask

    initial begin
        bus.stall_in = 1'b0;
        bus.flush = 1'b0;
        bus.ex_alu_result = 32'h0;
        bus.mem_rdata = 32'h0;
        setId(0, 0, 0, 0, 0);
        tick();
        test_reset();
        test_load_use();
        test_load_r0();
        test_forward_distance();
        test_freeze();
        test_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
